corr_result_rx: RTL and testbench

CORR_RESULT_RX -- requirements
Module: corr_result_rx

---
 rtl/corr_pkg.sv | 22 ++
 rtl/corr_tick_gen.sv | 33 +++
 rtl/corr_result_rx.sv | 198 +++++++++++++++++++
 tb/tb_corr_result_rx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// corr_pkg -- shared definitions for the correlator result receiver.
//   corr_state_t    : receiver FSM state encoding
//   M_DEF           : default clki cycles per sample tick
//   DATA_LENG_DEF   : default bits per captured word
//   DATA_TIMES_DEF  : default words per run
//   FIFO_DEPTH_DEF  : default output FIFO depth (power of 2)
//   FRAME_CNT_W     : width of the saturating frame counter
package corr_pkg;
  localparam int M_DEF          = 166667;
  localparam int DATA_LENG_DEF  = 32;
  localparam int DATA_TIMES_DEF = 2;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int FRAME_CNT_W    = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_PUSH  = 3'd2,
    ST_ACK   = 3'd3,
    ST_DONE  = 3'd4
  } corr_state_t;
endpackage

// File: rtl/corr_tick_gen.sv
// corr_tick_gen -- divide-by-M sample tick generator.
// Ports:
//   clki : clock
//   rst  : synchronous active-high reset (counter -> 0)
//   clr  : synchronous clear (counter -> 0), used to align ticks to a run start
//   tick : one-cycle pulse every M clki cycles, first pulse M cycles after clear
module corr_tick_gen
  import corr_pkg::*;
#(
  parameter int M = M_DEF
) (
  input  logic clki,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int               CNT_W = (M > 1) ? $clog2(M) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(M - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clki) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == LAST);
endmodule

// File: rtl/corr_result_rx.sv
// corr_result_rx -- collects serial correlator bits into DATA_LENG-bit words
// (LSB first, one sample per tick while corr_valid_in is high), queues each
// word in a small output FIFO and answers the upstream serializer with an
// M-cycle data_out handshake. A run captures DATA_TIMES words.
// Ports:
//   clki, rst          : clock, synchronous active-high reset
//   start              : pulse; begins a run from IDLE or DONE (ignored when busy)
//   corr_bit_in        : serial data bit
//   corr_valid_in      : corr_bit_in is valid
//   word_out           : FIFO head word (0 when empty)
//   word_valid         : FIFO non-empty
//   word_ready         : consumer pop (valid && ready)
//   data_out           : word-done handshake, high for M cycles per word
//   frame_cnt          : words written this run (saturating)
//   busy               : run in progress
//   overflow           : sticky, a completed word found the FIFO full
// Optional (macro CORR_RX_CHECK_EN):
//   expected           : reference word
//   mismatch_cnt       : saturating count of written words != expected
module corr_result_rx
  import corr_pkg::*;
#(
  parameter int M          = M_DEF,
  parameter int DATA_LENG  = DATA_LENG_DEF,
  parameter int DATA_TIMES = DATA_TIMES_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clki,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   corr_bit_in,
  input  logic                   corr_valid_in,
  output logic [DATA_LENG-1:0]   word_out,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   data_out,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   busy,
  output logic                   overflow
`ifdef CORR_RX_CHECK_EN
  ,
  input  logic [DATA_LENG-1:0]   expected,
  output logic [7:0]             mismatch_cnt
`endif
);
  localparam int BIT_W = (DATA_LENG > 1) ? $clog2(DATA_LENG) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ACK_W = (M > 1) ? $clog2(M) : 1;

  localparam logic [BIT_W-1:0]       BIT_LAST   = BIT_W'(DATA_LENG - 1);
  localparam logic [PTR_W-1:0]       PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ACK_W-1:0]       ACK_LAST   = ACK_W'(M - 1);
  localparam logic [PTR_W:0]         FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [FRAME_CNT_W-1:0] FRAMES_END = FRAME_CNT_W'(DATA_TIMES);

  corr_state_t r_state, w_state_next;

  logic                   w_tick;
  logic                   w_start_ok;
  logic                   w_sample;
  logic                   w_last_bit;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_ack_last;

  logic [BIT_W-1:0]       r_bit_cnt;
  logic [DATA_LENG-1:0]   r_shift;
  logic [ACK_W-1:0]       r_ack_cnt;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   r_overflow;

  logic [DATA_LENG-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W:0]         r_count;

  // Tick phase restarts on every accepted start so a run's sampling grid is
  // fixed relative to the start pulse.
  corr_tick_gen #(.M(M)) u_tick (
    .clki (clki),
    .rst  (rst),
    .clr  (w_start_ok),
    .tick (w_tick)
  );

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_sample   = (r_state == ST_SHIFT) && w_tick && corr_valid_in;
  assign w_last_bit = (r_bit_cnt == BIT_LAST);
  assign w_full     = (r_count == FIFO_FULL);
  assign w_pop      = word_valid && word_ready;
  // A full FIFO blocks the write even when a pop happens in the same cycle;
  // the word is written one cycle later from the freed slot.
  assign w_push     = (r_state == ST_PUSH) && !w_full;
  assign w_ack_last = (r_ack_cnt == ACK_LAST);

  always_ff @(posedge clki) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start)                  w_state_next = ST_SHIFT;
      ST_SHIFT:         if (w_sample && w_last_bit) w_state_next = ST_PUSH;
      ST_PUSH:          if (!w_full)                w_state_next = ST_ACK;
      ST_ACK: begin
        if (w_ack_last) begin
          w_state_next = (r_frame_cnt == FRAMES_END) ? ST_DONE : ST_SHIFT;
        end
      end
      default:                                      w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ack_cnt   <= '0;
      r_frame_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_bit_cnt   <= '0;
        r_shift     <= '0;
        r_frame_cnt <= '0;
      end
      // Bit counter wraps after the last bit, so the next word starts at 0.
      if (w_sample) begin
        r_shift[r_bit_cnt] <= corr_bit_in;
        r_bit_cnt          <= w_last_bit ? '0 : r_bit_cnt + BIT_W'(1);
      end
      if (r_state == ST_PUSH) begin
        if (!w_full) begin
          if (r_frame_cnt != {FRAME_CNT_W{1'b1}}) begin
            r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
          end
        end else if (!w_pop) begin
          r_overflow <= 1'b1;
        end
      end
      if (r_state == ST_ACK) begin
        r_ack_cnt <= w_ack_last ? '0 : r_ack_cnt + ACK_W'(1);
      end else begin
        r_ack_cnt <= '0;
      end
    end
  end

  // FIFO storage carries no reset; emptiness is tracked by r_count alone.
  always_ff @(posedge clki) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign word_valid = (r_count != '0);
  assign word_out   = word_valid ? r_mem[r_rd_ptr] : '0;
  assign data_out   = (r_state == ST_ACK);
  assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign frame_cnt  = r_frame_cnt;
  assign overflow   = r_overflow;

`ifdef CORR_RX_CHECK_EN
  logic [7:0] r_mismatch_cnt;

  always_ff @(posedge clki) begin
    if (rst || w_start_ok) begin
      r_mismatch_cnt <= '0;
    end else if (w_push && (r_shift != expected) && (r_mismatch_cnt != 8'hFF)) begin
      r_mismatch_cnt <= r_mismatch_cnt + 8'd1;
    end
  end

  assign mismatch_cnt = r_mismatch_cnt;
`endif
endmodule

// File: tb/tb_corr_result_rx.sv
// tb_corr_result_rx -- self-checking bench for corr_result_rx (M=4,
// DATA_LENG=32, DATA_TIMES=2, FIFO_DEPTH=4). Words are pushed to a scoreboard
// queue as they are driven and compared when the consumer pops them.
// Define CORR_RX_CHECK_EN to also exercise the mismatch counter.
module tb_corr_result_rx;
  localparam int M  = 4;
  localparam int DL = 32;
  localparam int DT = 2;
  localparam int FD = 4;

  logic          clki = 1'b0;
  logic          rst;
  logic          start;
  logic          corr_bit_in;
  logic          corr_valid_in;
  logic [DL-1:0] word_out;
  logic          word_valid;
  logic          word_ready;
  logic          data_out;
  logic [11:0]   frame_cnt;
  logic          busy;
  logic          overflow;
`ifdef CORR_RX_CHECK_EN
  logic [DL-1:0] expected;
  logic [7:0]    mismatch_cnt;
`endif

  corr_result_rx #(
    .M          (M),
    .DATA_LENG  (DL),
    .DATA_TIMES (DT),
    .FIFO_DEPTH (FD)
  ) dut (
    .clki          (clki),
    .rst           (rst),
    .start         (start),
    .corr_bit_in   (corr_bit_in),
    .corr_valid_in (corr_valid_in),
    .word_out      (word_out),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .data_out      (data_out),
    .frame_cnt     (frame_cnt),
    .busy          (busy),
    .overflow      (overflow)
`ifdef CORR_RX_CHECK_EN
    ,
    .expected      (expected),
    .mismatch_cnt  (mismatch_cnt)
`endif
  );

  always #5 clki = ~clki;

  int cyc = 0;
  int c0  = 0;
  always @(posedge clki) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Scoreboard: a pop happens at the posedge following a negedge where
  // valid && ready is seen.
  always @(negedge clki) begin
    logic [31:0] exp_w;
    if (word_valid && word_ready) begin
      if (exp_q.size() != 0) exp_w = exp_q.pop_front();
      else                   exp_w = ~word_out;  // nothing expected: force a miscompare
      check_eq("pop_word", word_out, exp_w);
    end
  end

  task automatic step();
    @(posedge clki);
    #1;
  endtask

  task automatic tick_window();
    repeat (M) step();
  endtask

  // Sampling edges sit at c0 + k*M; drive a new bit right after one of them.
  task automatic align_grid();
    int guard = 0;
    while ((((cyc - c0) % M) != 0) && (guard < 2 * M)) begin
      step();
      guard++;
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits, input int gap_at, input int start_at);
    for (int b = 0; b < nbits; b++) begin
      if (b == gap_at) begin
        corr_valid_in = 1'b0;
        corr_bit_in   = ~w[b];
        repeat (3) tick_window();
      end
      corr_valid_in = 1'b1;
      corr_bit_in   = w[b];
      if (b == start_at) begin
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (M - 1) step();
      end else begin
        tick_window();
      end
    end
    corr_valid_in = 1'b0;
    corr_bit_in   = 1'b0;
  endtask

  task automatic wait_ack_rise(input string tag);
    int n = 0;
    while (!data_out && (n < 400)) begin
      step();
      n++;
    end
    check_eq({tag, "_ack_seen"}, 32'(data_out), 32'd1);
  endtask

  task automatic measure_ack(input string tag);
    int w = 0;
    while (data_out && (w < 4 * M)) begin
      w++;
      step();
    end
    check_eq({tag, "_ack_len"}, 32'(w), 32'(M));
  endtask

  task automatic do_word(input string tag, input logic [31:0] w, input int gap_at,
                         input int start_at, input int exp_frame);
    send_bits(w, 32, gap_at, start_at);
    exp_q.push_back(w);
    wait_ack_rise(tag);
    check_eq({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frame));
    check_eq({tag, "_word_valid"}, 32'(word_valid), 32'd1);
    measure_ack(tag);
    align_grid();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    word_ready = 1'b1;
    while (word_valid && (n < 64)) begin
      step();
      n++;
    end
    word_ready = 1'b0;
    check_eq({tag, "_empty"}, 32'(word_valid), 32'd0);
    check_eq({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    corr_bit_in   = 1'b0;
    corr_valid_in = 1'b0;
    word_ready    = 1'b0;
`ifdef CORR_RX_CHECK_EN
    expected      = 32'hFFFF_FFFF;
`endif
    repeat (3) step();
    rst = 1'b0;
    step();

    check_eq("rst_word_valid", 32'(word_valid), 32'd0);
    check_eq("rst_word_out",   word_out,        32'd0);
    check_eq("rst_data_out",   32'(data_out),   32'd0);
    check_eq("rst_frame_cnt",  32'(frame_cnt),  32'd0);
    check_eq("rst_busy",       32'(busy),       32'd0);
    check_eq("rst_overflow",   32'(overflow),   32'd0);

    // Run A: basic capture, then a word with a 3-tick valid gap.
    start_run();
    check_eq("runA_busy", 32'(busy), 32'd1);
    do_word("capA", 32'hA5A5_0F0F, -1, -1, 1);
    do_word("gapB", 32'hDEAD_BEEF, 13, -1, 2);
    check_eq("runA_done_busy", 32'(busy), 32'd0);
    check_eq("runA_done_frames", 32'(frame_cnt), 32'd2);
    drain("runA");

    // Run B: ordering of 0x1 then 0x8000_0000; a start mid-word is ignored.
    start_run();
    do_word("one", 32'h0000_0001, -1, 10, 1);
    do_word("msb", 32'h8000_0000, -1, -1, 2);
    check_eq("runB_done_busy", 32'(busy), 32'd0);
    check_eq("runB_done_frames", 32'(frame_cnt), 32'd2);
    drain("runB");

    // Run C: fill the FIFO over two runs, then stall the fifth word.
    start_run();
    do_word("fill1", 32'hC000_0001, -1, -1, 1);
    do_word("fill2", 32'hC000_0002, -1, -1, 2);
    start_run();
    do_word("fill3", 32'hC000_0003, -1, -1, 1);
    do_word("fill4", 32'hC000_0004, -1, -1, 2);
    check_eq("full_no_overflow", 32'(overflow), 32'd0);
    start_run();
    send_bits(32'hC000_0005, 32, -1, -1);
    exp_q.push_back(32'hC000_0005);
    repeat (2 * M) step();
    check_eq("stall_data_out", 32'(data_out), 32'd0);
    check_eq("stall_overflow", 32'(overflow), 32'd1);
    check_eq("stall_busy", 32'(busy), 32'd1);
    check_eq("stall_frame_cnt", 32'(frame_cnt), 32'd0);
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    check_eq("push_waits", 32'(data_out), 32'd0);
    step();
    check_eq("push_done", 32'(data_out), 32'd1);
    check_eq("push_frame_cnt", 32'(frame_cnt), 32'd1);
    measure_ack("stall");
    align_grid();
    drain("runC_mid");
    do_word("after", 32'hC000_0006, -1, -1, 2);
    check_eq("runC_done_busy", 32'(busy), 32'd0);
    check_eq("overflow_sticky", 32'(overflow), 32'd1);
    drain("runC");

    // Run D: reset mid-word discards the partial word and the queued one.
    start_run();
    do_word("pre_rst", 32'h5555_AAAA, -1, -1, 1);
    send_bits(32'h1234_5678, 10, -1, -1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check_eq("mid_rst_word_valid", 32'(word_valid), 32'd0);
    check_eq("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_eq("mid_rst_data_out", 32'(data_out), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_overflow", 32'(overflow), 32'd0);
    start_run();
    do_word("clean1", 32'h1234_5678, -1, -1, 1);
    do_word("clean2", 32'h0F0F_0F0F, -1, -1, 2);
    drain("runD");

`ifdef CORR_RX_CHECK_EN
    // Run E: one of two words differs from the reference.
    start_run();
    check_eq("mm_cleared", 32'(mismatch_cnt), 32'd0);
    do_word("mm1", 32'hFFFF_FFFE, -1, -1, 1);
    do_word("mm2", 32'hFFFF_FFFF, -1, -1, 2);
    check_eq("mismatch_cnt", 32'(mismatch_cnt), 32'd1);
    drain("runE");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
